// File: rtl/xorshift32.sv
// xorshift32: 32-bit Marsaglia xorshift generator (x^=x<<13; x^=x>>17; x^=x<<5).
// Each accepted start request runs one shift stage per clock. The finished word
// is published on random, and ready_n is driven low for that word.
module xorshift32 #(
    parameter logic [31:0] SEED = 32'h92D6_8CA2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_n,
    output logic [31:0] random,
    output logic        ready_n
);

    // An all-zero state would lock the generator at zero, so substitute the default.
    localparam logic [31:0] DEFAULT_SEED = 32'h92D6_8CA2;
    localparam logic [31:0] SEED_EFF     = (SEED == 32'h0) ? DEFAULT_SEED : SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SH13 = 2'd1,
        SH17 = 2'd2,
        SH5  = 2'd3
    } fsm_t;

    fsm_t        fsm;
    fsm_t        fsm_nxt;
    logic [31:0] state;
    logic [31:0] t;

    // The three xorshift stages. All shifts are logical and truncated to 32 bits.
    function automatic logic [31:0] sh13_step(input logic [31:0] x);
        return x ^ (x << 13);
    endfunction

    function automatic logic [31:0] sh17_step(input logic [31:0] x);
        return x ^ (x >> 17);
    endfunction

    function automatic logic [31:0] sh5_step(input logic [31:0] x);
        return x ^ (x << 5);
    endfunction

    // FSM state register; an asynchronous reset aborts any step in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state logic. start_n is only honoured in IDLE, so requests made while busy are dropped.
    always_comb begin
        fsm_nxt = fsm;
        unique case (fsm)
            IDLE:    if (!start_n) fsm_nxt = SH13;
            SH13:    fsm_nxt = SH17;
            SH17:    fsm_nxt = SH5;
            SH5:     fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Scratch register for the intermediate stage results.
    // It is never observed directly, so it needs no reset.
    always_ff @(posedge clk) begin
        unique case (fsm)
            SH13:    t <= sh13_step(state);
            SH17:    t <= sh17_step(t);
            default: t <= t;
        endcase
    end

    // Architectural state and outputs.
    // random only changes when a word completes, so intermediate values never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SEED_EFF;
            random  <= 32'h0;
            ready_n <= 1'b1;
        end else begin
            if (fsm == IDLE && !start_n) begin
                ready_n <= 1'b1;
            end
            if (fsm == SH5) begin
                state   <= sh5_step(t);
                random  <= sh5_step(t);
                ready_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xorshift32.sv
// Self-checking bench for xorshift32. It compares the DUT against a software
// xorshift32 model, using both directed and randomised request patterns.
module tb_xorshift32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_n = 1'b1;
    logic [31:0] random;
    logic        ready_n;
    logic [31:0] random_z;
    logic        ready_n_z;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_state;   // software model state
    logic [31:0] m_random;  // last word the model says is published

    localparam logic [31:0] DEF_SEED = 32'h92D6_8CA2;

    // Instance under test with the default seed.
    xorshift32 #(.SEED(DEF_SEED)) dut (
        .clk(clk), .rst(rst), .start_n(start_n), .random(random), .ready_n(ready_n)
    );

    // Instance with SEED=0; the default seed must be substituted.
    xorshift32 #(.SEED(32'h0)) dut_z (
        .clk(clk), .rst(rst), .start_n(start_n), .random(random_z), .ready_n(ready_n_z)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] xs_model(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request: start is sampled at the first edge, and the word appears after edge N+3.
    // Setting noisy=1 puts random start_n values on the busy cycles; the DUT must ignore them.
    task automatic do_word(input bit noisy, input string tag);
        logic [31:0] exp;
        exp = xs_model(m_state);
        start_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            start_n = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            n_cmp++;
            if (ready_n !== 1'b1 || random !== m_random) begin
                n_err++;
                $display("FAIL %s busy%0d: ready_n=%b random=%h, required ready_n=1 random=%h",
                         tag, k, ready_n, random, m_random);
            end
        end
        step();
        start_n = 1'b1;
        m_state  = exp;
        m_random = exp;
        n_cmp++;
        if (ready_n !== 1'b0 || random !== exp) begin
            n_err++;
            $display("FAIL %s done: ready_n=%b random=%h, required ready_n=0 random=%h",
                     tag, ready_n, random, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_n = 1'b1;
        step(); step();
        n_cmp++;
        if (random !== 32'h0 || ready_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold: random=%h ready_n=%b, required 0/1", random, ready_n);
        end
        start_n = 1'b0;   // must be ignored while rst is high
        step(); step();
        n_cmp++;
        if (random !== 32'h0 || ready_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ignore_start: random=%h ready_n=%b, required 0/1", random, ready_n);
        end
        start_n = 1'b1;
        rst = 1'b0;
        m_state  = DEF_SEED;
        m_random = 32'h0;
        step(); step(); step();
        n_cmp++;
        if (random !== 32'h0 || ready_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: random=%h ready_n=%b, required 0/1", random, ready_n);
        end
    endtask

    task automatic test_first_words();
        do_word(1'b0, "word1");
        n_cmp++;
        if (random !== 32'h2B1F4D63) begin
            n_err++;
            $display("FAIL word1_const: random=%h required 2b1f4d63", random);
        end
        step(); step();
        do_word(1'b0, "word2");
        n_cmp++;
        if (random !== 32'h94DACB7A) begin
            n_err++;
            $display("FAIL word2_const: random=%h required 94dacb7a", random);
        end
    endtask

    task automatic test_continuous();
        start_n = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k % 4 == 0) begin
                m_state  = xs_model(m_state);
                m_random = m_state;
            end
            n_cmp++;
            if (ready_n !== ((k % 4 == 0) ? 1'b0 : 1'b1) || random !== m_random) begin
                n_err++;
                $display("FAIL continuous cyc%0d: ready_n=%b random=%h, required ready_n=%b random=%h",
                         k, ready_n, random, (k % 4 == 0) ? 1'b0 : 1'b1, m_random);
            end
        end
        start_n = 1'b1;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] exp;
        exp = xs_model(m_state);
        step();
        start_n = 1'b0;
        step();            // edge N: start sampled, now SH13
        start_n = 1'b1;
        step();            // edge N+1: now SH17
        start_n = 1'b0;    // pulse seen at the SH17 edge; must be dropped
        step();            // edge N+2: now SH5
        start_n = 1'b1;
        step();            // edge N+3: word done
        m_state  = exp;
        m_random = exp;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (ready_n !== 1'b0 || random !== exp) begin
                n_err++;
                $display("FAIL busy_ignore idle%0d: ready_n=%b random=%h, required 0 / %h",
                         k, ready_n, random, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        step();
        start_n = 1'b0;
        step();            // now in SH13
        start_n = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (random !== 32'h0 || ready_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: random=%h ready_n=%b, required 0/1", random, ready_n);
        end
        step(); step();
        n_cmp++;
        if (random !== 32'h0 || ready_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_hold: random=%h ready_n=%b, required 0/1", random, ready_n);
        end
        rst = 1'b0;
        m_state  = DEF_SEED;
        m_random = 32'h0;
        step();
        do_word(1'b0, "after_reset");
        n_cmp++;
        if (random !== 32'h2B1F4D63) begin
            n_err++;
            $display("FAIL after_reset_const: random=%h required 2b1f4d63", random);
        end
    endtask

    task automatic test_seed_zero();
        n_cmp++;
        if (random_z !== 32'h2B1F4D63 || ready_n_z !== 1'b0) begin
            n_err++;
            $display("FAIL seed_zero: random=%h ready_n=%b, required 2b1f4d63/0", random_z, ready_n_z);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                step();
                n_cmp++;
                if (random !== m_random || ready_n !== 1'b0) begin
                    n_err++;
                    $display("FAIL random_gap%0d: random=%h ready_n=%b, required %h/0",
                             i, random, ready_n, m_random);
                end
            end
            do_word(1'b1, "random_word");
        end
        n_cmp++;
        if (random_z !== m_random) begin
            n_err++;
            $display("FAIL seed_zero_track: random=%h required %h", random_z, m_random);
        end
    endtask

    initial begin
        test_reset();
        test_first_words();
        test_continuous();
        test_busy_ignore();
        test_reset_mid();
        test_seed_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
